// File: rtl/lut_neuron_loader_if.sv
// Config-load and lookup signal bundle for the LUT neuron.
// The master side drives requests and config beats; the slave is the neuron.
interface lut_neuron_loader_if #(
   parameter int IN_BITS  = 4,
   parameter int OUT_BITS = 2,
   parameter int CFG_W    = 8
);
   logic                cfg_start;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [CFG_W-1:0]    cfg_data;
   logic                cfg_last;
   logic                cfg_err;
   logic                loaded;
   logic                in_valid;
   logic [IN_BITS-1:0]  in_data;
   logic                out_valid;
   logic [OUT_BITS-1:0] out_data;

   modport master (
      output cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_data,
      input  cfg_ready, cfg_err, loaded, out_valid, out_data
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_data,
      output cfg_ready, cfg_err, loaded, out_valid, out_data
   );
endinterface

// File: rtl/lut_neuron_loader.sv
// LUT neuron: truth table loaded over a framed config stream, then looked up
// one request per cycle through a registered output.
module lut_neuron_loader #(
   parameter int IN_BITS  = 4,
   parameter int OUT_BITS = 2,
   parameter int CFG_W    = 8
) (
   input logic               clk,
   input logic               rst_n,
   lut_neuron_loader_if.slave io
);
   localparam int DEPTH = 1 << IN_BITS;
   localparam int BEATS = DEPTH * OUT_BITS / CFG_W;
   localparam int EPB   = CFG_W / OUT_BITS;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [BW-1:0]       beat_q, beat_d;
   logic                loaded_q, loaded_d;
   logic                err_q, err_d;
   logic                out_valid_q, out_valid_d;
   logic [OUT_BITS-1:0] out_data_q, out_data_d;
   logic [OUT_BITS-1:0] table_q [DEPTH];

   logic                cfg_ready;
   logic                accept;
   logic                last_beat;
   logic                wr_en;
   logic                lookup_en;
   logic [IN_BITS-1:0]  wr_base;

   // A start request always wins, so the stream is stalled during that cycle.
   assign cfg_ready = (state_q == LOAD) && !io.cfg_start;
   assign accept    = cfg_ready && io.cfg_valid;
   assign last_beat = (beat_q == BW'(BEATS - 1));
   assign wr_base   = IN_BITS'(int'(beat_q) * EPB);
   assign lookup_en = (state_q == RUN) && io.in_valid;

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      loaded_d = loaded_q;
      err_d    = err_q;
      wr_en    = 1'b0;
      if (io.cfg_start) begin
         state_d  = LOAD;
         beat_d   = '0;
         loaded_d = 1'b0;
         err_d    = 1'b0;
      end else if (accept) begin
         wr_en = 1'b1;
         if (last_beat && io.cfg_last) begin
            state_d  = RUN;
            loaded_d = 1'b1;
         end else if (last_beat || io.cfg_last) begin
            // Framing error: partial table stays in storage but is invalid.
            state_d  = IDLE;
            loaded_d = 1'b0;
            err_d    = 1'b1;
         end else begin
            beat_d = beat_q + BW'(1);
         end
      end
   end

   // The table is still RUN-readable in a cfg_start cycle, so a concurrent
   // lookup sees the old contents.
   always_comb begin
      out_valid_d = lookup_en;
      out_data_d  = lookup_en ? table_q[io.in_data] : out_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         loaded_q    <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         loaded_q    <= loaded_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Register-based table: async clear and a combinational read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= '0;
         end
      end else if (wr_en) begin
         for (int k = 0; k < EPB; k++) begin
            table_q[wr_base + IN_BITS'(k)] <= io.cfg_data[k*OUT_BITS +: OUT_BITS];
         end
      end
   end

   assign io.cfg_ready = cfg_ready;
   assign io.cfg_err   = err_q;
   assign io.loaded    = loaded_q;
   assign io.out_valid = out_valid_q;
   assign io.out_data  = out_data_q;
endmodule
